// File: rtl/alu_issue_ctrl.sv
// Issue controller for the W0RM ALU unit interface: accepts one op, pulses it to the unit,
// waits for the result (or times out) and holds it for writeback until accepted.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_op_valid,
  output logic                  o_op_ready,
  input  logic [3:0]            i_op_opcode,
  input  logic                  i_op_ext_8_16,
  input  logic [DATA_WIDTH-1:0] i_op_data_a,
  input  logic [DATA_WIDTH-1:0] i_op_data_b,
  input  logic [3:0]            i_op_dest,
  output logic                  o_alu_data_valid,
  output logic [3:0]            o_alu_opcode,
  output logic                  o_alu_ext_8_16,
  output logic [DATA_WIDTH-1:0] o_alu_data_a,
  output logic [DATA_WIDTH-1:0] o_alu_data_b,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_result_valid,
  input  logic [3:0]            i_alu_result_flags,
  output logic                  o_wb_valid,
  input  logic                  i_wb_ready,
  output logic [DATA_WIDTH-1:0] o_wb_result,
  output logic [3:0]            o_wb_flags,
  output logic [3:0]            o_wb_dest,
  output logic                  o_wb_error
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_HOLD = 2'd3} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_cnt;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_timeout;
  logic [3:0]            r_opcode;
  logic                  r_ext;
  logic [DATA_WIDTH-1:0] r_data_a;
  logic [DATA_WIDTH-1:0] r_data_b;
  logic [3:0]            r_dest;
  logic [DATA_WIDTH-1:0] r_result;
  logic [3:0]            r_flags;
  logic                  r_error;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and completion decode; a result on the last WAIT cycle wins over timeout
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_op_valid) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (i_alu_result_valid) begin
          w_capture = 1'b1;
          w_next    = S_HOLD;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_alu_result_valid) begin
          w_capture = 1'b1;
          w_next    = S_HOLD;
        end else if (r_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_HOLD;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_HOLD: begin
        if (i_wb_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_HOLD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    o_op_ready       = 1'b0;
    o_alu_data_valid = 1'b0;
    o_wb_valid       = 1'b0;
    case (r_state)
      S_IDLE:  o_op_ready       = 1'b1;
      S_ISSUE: o_alu_data_valid = 1'b1;
      S_HOLD:  o_wb_valid       = 1'b1;
      default: o_op_ready       = 1'b0;
    endcase
  end

  // Operand, tag, wait-counter and completion capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= 4'd0;
      r_ext    <= 1'b0;
      r_data_a <= '0;
      r_data_b <= '0;
      r_dest   <= 4'd0;
      r_cnt    <= 8'd0;
      r_result <= '0;
      r_flags  <= 4'd0;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opcode <= i_op_opcode;
        r_ext    <= i_op_ext_8_16;
        r_data_a <= i_op_data_a;
        r_data_b <= i_op_data_b;
        r_dest   <= i_op_dest;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= 8'd0;
      end else if (r_state == S_WAIT && !w_capture && !w_timeout) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_capture) begin
        r_result <= i_alu_result;
        r_flags  <= i_alu_result_flags;
        r_error  <= 1'b0;
      end else if (w_timeout) begin
        r_result <= '0;
        r_flags  <= 4'd0;
        r_error  <= 1'b1;
      end
    end
  end

  assign o_alu_opcode   = r_opcode;
  assign o_alu_ext_8_16 = r_ext;
  assign o_alu_data_a   = r_data_a;
  assign o_alu_data_b   = r_data_b;
  assign o_wb_result    = r_result;
  assign o_wb_flags     = r_flags;
  assign o_wb_dest      = r_dest;
  assign o_wb_error     = r_error;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: registered/single-cycle units, timeout, backpressure,
// reset while waiting and stray result strobes.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_opcode;
  logic        op_ext;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_dest;
  logic        alu_dv;
  logic [3:0]  alu_opcode;
  logic        alu_ext;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_rv;
  logic [3:0]  alu_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic [3:0]  wb_flags;
  logic [3:0]  wb_dest;
  logic        wb_error;

  int n_total = 0;
  int n_bad   = 0;

  alu_issue_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_op_valid(op_valid), .o_op_ready(op_ready), .i_op_opcode(op_opcode),
    .i_op_ext_8_16(op_ext), .i_op_data_a(op_a), .i_op_data_b(op_b), .i_op_dest(op_dest),
    .o_alu_data_valid(alu_dv), .o_alu_opcode(alu_opcode), .o_alu_ext_8_16(alu_ext),
    .o_alu_data_a(alu_a), .o_alu_data_b(alu_b),
    .i_alu_result(alu_result), .i_alu_result_valid(alu_rv), .i_alu_result_flags(alu_flags),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_result(wb_result),
    .o_wb_flags(wb_flags), .o_wb_dest(wb_dest), .o_wb_error(wb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, drive the unit strobe at cycle rv_at after accept (-1: never), measure the
  // accept-to-wb_valid latency, optionally backpressure with a second op pending, then retire.
  task automatic do_op(input logic [3:0] opc, input logic ext, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] dest, input int rv_at,
                       input logic [31:0] res, input logic [3:0] flg, input int exp_lat,
                       input logic [31:0] exp_res, input logic [3:0] exp_flg,
                       input logic exp_err, input int hold_n);
    int t;
    bit seen;
    op_valid  = 1'b1;
    op_opcode = opc;
    op_ext    = ext;
    op_a      = a;
    op_b      = b;
    op_dest   = dest;
    chk("accept_ready", op_ready, 1'b1);
    t    = 0;
    seen = 1'b0;
    while (!seen && t < 40) begin
      step();
      t++;
      op_valid = 1'b0;
      alu_rv   = 1'b0;
      if (wb_valid) begin
        seen = 1'b1;
      end else begin
        chk("busy_not_ready", op_ready, 1'b0);
        if (t == 1) begin
          chk("issue_strobe", alu_dv, 1'b1);
          chk("issue_opcode", alu_opcode, opc);
          chk("issue_ext", alu_ext, ext);
          chk("issue_a", alu_a, a);
          chk("issue_b", alu_b, b);
        end
        if (t == 2) chk("strobe_once", alu_dv, 1'b0);
        if (t == rv_at) begin
          alu_rv     = 1'b1;
          alu_result = res;
          alu_flags  = flg;
        end
      end
    end
    chk("latency", t, exp_lat);
    chk("wb_result", wb_result, exp_res);
    chk("wb_flags", wb_flags, exp_flg);
    chk("wb_dest", wb_dest, dest);
    chk("wb_error", wb_error, exp_err);
    for (int i = 0; i < hold_n; i++) begin
      op_valid  = 1'b1;
      op_opcode = 4'h1;
      op_ext    = 1'b0;
      op_a      = 32'h0000_0005;
      op_b      = 32'h0000_0007;
      op_dest   = 4'h9;
      step();
      chk("hold_valid", wb_valid, 1'b1);
      chk("hold_result", wb_result, exp_res);
      chk("hold_dest", wb_dest, dest);
      chk("hold_not_ready", op_ready, 1'b0);
      chk("hold_no_issue", alu_dv, 1'b0);
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("retire_wb_low", wb_valid, 1'b0);
    chk("retire_ready", op_ready, 1'b1);
    chk("retire_no_issue", alu_dv, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    op_valid   = 1'b0;
    op_opcode  = 4'h0;
    op_ext     = 1'b0;
    op_a       = 32'h0;
    op_b       = 32'h0;
    op_dest    = 4'h0;
    alu_result = 32'h0;
    alu_rv     = 1'b0;
    alu_flags  = 4'h0;
    wb_ready   = 1'b0;
    #12;
    chk("rst_op_ready", op_ready, 1'b1);
    chk("rst_alu_dv", alu_dv, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_result", wb_result, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // registered SEX: result one cycle after issue
    do_op(4'hA, 1'b0, 32'h0000_0080, 32'h0, 4'h3, 2, 32'hFFFF_FF80, 4'h2,
          3, 32'hFFFF_FF80, 4'h2, 1'b0, 0);
    // single-cycle ZEX: result in the issue cycle
    do_op(4'hB, 1'b1, 32'hABCD_8000, 32'h0, 4'h5, 1, 32'h0000_8000, 4'h0,
          2, 32'h0000_8000, 4'h0, 1'b0, 0);
    // no result: timeout error completion
    do_op(4'h2, 1'b0, 32'h1111_1111, 32'h2222_2222, 4'h6, -1, 32'h5555_5555, 4'hF,
          17, 32'h0, 4'h0, 1'b1, 0);
    // result on the final wait cycle wins over timeout
    do_op(4'h3, 1'b0, 32'h3, 32'h4, 4'h7, 16, 32'h0000_0077, 4'h8,
          17, 32'h0000_0077, 4'h8, 1'b0, 0);
    // backpressure with a second op pending, which is then accepted in order
    do_op(4'h4, 1'b0, 32'h10, 32'h20, 4'h2, 2, 32'h0000_CAFE, 4'h1,
          3, 32'h0000_CAFE, 4'h1, 1'b0, 5);
    do_op(4'h1, 1'b0, 32'h5, 32'h7, 4'h9, 2, 32'h0000_000C, 4'h0,
          3, 32'h0000_000C, 4'h0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_dup_issue", alu_dv, 1'b0);
      chk("no_dup_wb", wb_valid, 1'b0);
    end

    // reset while waiting for a registered unit
    op_valid  = 1'b1;
    op_opcode = 4'h6;
    op_a      = 32'hAAAA_0000;
    op_dest   = 4'hC;
    step();
    op_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rstw_wb_valid", wb_valid, 1'b0);
    chk("rstw_alu_dv", alu_dv, 1'b0);
    chk("rstw_op_ready", op_ready, 1'b1);
    chk("rstw_alu_a", alu_a, 32'h0);
    step();
    rst_n      = 1'b1;
    alu_rv     = 1'b1;
    alu_result = 32'h0000_DEAD;
    alu_flags  = 4'h3;
    step();
    alu_rv = 1'b0;
    chk("late_rv_wb", wb_valid, 1'b0);
    chk("late_rv_ready", op_ready, 1'b1);
    chk("late_rv_result", wb_result, 32'h0);
    do_op(4'h5, 1'b0, 32'h1, 32'h2, 4'hE, 2, 32'h1111_2222, 4'h4,
          3, 32'h1111_2222, 4'h4, 1'b0, 0);

    // stray result strobe in IDLE
    alu_rv     = 1'b1;
    alu_result = 32'h0000_1234;
    alu_flags  = 4'h1;
    step();
    alu_rv = 1'b0;
    chk("stray_wb", wb_valid, 1'b0);
    chk("stray_ready", op_ready, 1'b1);
    chk("stray_result", wb_result, 32'h1111_2222);
    chk("stray_flags", wb_flags, 4'h4);
    step();
    chk("stray_wb2", wb_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
